// File: rtl/mem_access_seq_pkg.sv
// Shared definitions for the multicycle memory sequencer:
// state encodings, memory latency bounds and opcodes.
package mem_access_seq_pkg;

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_FWAIT = 3'd1,
    S_EXEC  = 3'd2,
    S_DATA  = 3'd3,
    S_DWAIT = 3'd4,
    S_WB    = 3'd5,
    S_HALT  = 3'd6
  } state_e;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 3;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  function automatic logic [1:0] lat_init(input int lat);
    return 2'(lat - 1);
  endfunction

endpackage

// File: rtl/mem_access_seq_if.sv
// Unified single-port memory bus driven by the sequencer.
// Master drives strobe, write enable and address.
interface mem_access_seq_if #(
  parameter int XLEN = 32
);
  logic            mem_en;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;

  modport master (output mem_en, mem_we, mem_addr);
  modport slave  (input  mem_en, mem_we, mem_addr);
endinterface

// File: rtl/mem_access_seq_wait_cnt.sv
// 2-bit memory wait counter: load, decrement, zero flag.
// Synchronous active-high reset clears the count.
module seq_wait_cnt
  import mem_access_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [1:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (rst)
      cnt_d = 2'd0;
    else if (load)
      cnt_d = load_val;
    else if (dec && cnt_q != 2'd0)
      cnt_d = cnt_q - 2'd1;
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == 2'd0);

endmodule

// File: rtl/mem_access_seq.sv
// Multicycle fetch/execute/data sequencer for a unified memory.
// Define MEM_ACCESS_SEQ_PERF_CNT_EN to add cycle/instret counters.
module mem_access_seq
  import mem_access_seq_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MEM_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] data_addr,
  input  logic            data_rd,
  input  logic            data_wr,
  input  logic            halt_in,
  mem_access_seq_if.master mem,
  output logic            ir_load,
  output logic            mdr_load,
  output logic            pc_en,
  output logic            rf_we_en,
`ifdef MEM_ACCESS_SEQ_PERF_CNT_EN
  output logic [XLEN-1:0] cycle_cnt,
  output logic [XLEN-1:0] instret_cnt,
`endif
  output logic            halted
);

  if (MEM_LAT < MEM_LAT_MIN ||
      MEM_LAT > MEM_LAT_MAX) begin : g_bad_lat
    $error("mem_access_seq: MEM_LAT out of range");
  end

  state_e          state_q, state_d;
  logic            cnt_load, cnt_dec, cnt_zero;
  logic            en, we, ir, mdr, pce, rfwe, hlt;
  logic [XLEN-1:0] addr;

  seq_wait_cnt u_wait (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (lat_init(MEM_LAT)),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    en       = 1'b0;
    we       = 1'b0;
    addr     = '0;
    ir       = 1'b0;
    mdr      = 1'b0;
    pce      = 1'b0;
    rfwe     = 1'b0;
    hlt      = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        en       = 1'b1;
        addr     = pc;
        cnt_load = 1'b1;
        state_d  = S_FWAIT;
      end
      S_FWAIT: begin
        if (cnt_zero) begin
          ir      = 1'b1;
          state_d = S_EXEC;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      S_EXEC: begin
        if (halt_in) begin
          state_d = S_HALT;
        end else if (data_wr || data_rd) begin
          state_d = S_DATA;
        end else begin
          pce     = 1'b1;
          rfwe    = 1'b1;
          state_d = S_FETCH;
        end
      end
      // a store wins over a simultaneous read
      S_DATA: begin
        en   = 1'b1;
        addr = data_addr;
        we   = data_wr;
        if (data_wr) begin
          state_d = S_WB;
        end else begin
          cnt_load = 1'b1;
          state_d  = S_DWAIT;
        end
      end
      S_DWAIT: begin
        if (cnt_zero) begin
          mdr     = 1'b1;
          state_d = S_WB;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      S_WB: begin
        pce     = 1'b1;
        rfwe    = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: hlt = 1'b1;
      default: state_d = S_FETCH;
    endcase
    if (rst) state_d = S_FETCH;
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
  end

  // reset silences every output, even in the reset FETCH state
  assign mem.mem_en   = en & ~rst;
  assign mem.mem_we   = we & ~rst;
  assign mem.mem_addr = rst ? '0 : addr;
  assign ir_load      = ir & ~rst;
  assign mdr_load     = mdr & ~rst;
  assign pc_en        = pce & ~rst;
  assign rf_we_en     = rfwe & ~rst;
  assign halted       = hlt & ~rst;

`ifdef MEM_ACCESS_SEQ_PERF_CNT_EN
  logic [XLEN-1:0] cycle_q, cycle_d;
  logic [XLEN-1:0] instret_q, instret_d;

  always_comb begin
    cycle_d   = cycle_q;
    instret_d = instret_q;
    if (rst) begin
      cycle_d   = '0;
      instret_d = '0;
    end else begin
      if (state_q != S_HALT)
        cycle_d = cycle_q + XLEN'(1);
      if (pce)
        instret_d = instret_q + XLEN'(1);
    end
  end

  always_ff @(posedge clk) begin
    cycle_q   <= cycle_d;
    instret_q <= instret_d;
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
`endif

endmodule

// File: tb/tb_mem_access_seq.sv
// Directed bench for mem_access_seq at MEM_LAT=1 and MEM_LAT=3.
// Perf-counter checks compile only with MEM_ACCESS_SEQ_PERF_CNT_EN.
module tb_mem_access_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic        rst1, rd1, wr1, halt1;
  logic [31:0] pc1, da1;
  logic        ir1, mdr1, pce1, rfw1, hlt1;
  logic        rst3, rd3, wr3, halt3;
  logic [31:0] pc3, da3;
  logic        ir3, mdr3, pce3, rfw3, hlt3;
`ifdef MEM_ACCESS_SEQ_PERF_CNT_EN
  logic [31:0] cyc1, ins1, cyc3, ins3;
`endif

  mem_access_seq_if #(.XLEN(32)) m1 ();
  mem_access_seq_if #(.XLEN(32)) m3 ();

  mem_access_seq #(.XLEN(32), .MEM_LAT(1)) u1 (
    .clk(clk), .rst(rst1), .pc(pc1), .data_addr(da1),
    .data_rd(rd1), .data_wr(wr1), .halt_in(halt1),
    .mem(m1.master), .ir_load(ir1), .mdr_load(mdr1),
    .pc_en(pce1), .rf_we_en(rfw1),
`ifdef MEM_ACCESS_SEQ_PERF_CNT_EN
    .cycle_cnt(cyc1), .instret_cnt(ins1),
`endif
    .halted(hlt1)
  );

  mem_access_seq #(.XLEN(32), .MEM_LAT(3)) u3 (
    .clk(clk), .rst(rst3), .pc(pc3), .data_addr(da3),
    .data_rd(rd3), .data_wr(wr3), .halt_in(halt3),
    .mem(m3.master), .ir_load(ir3), .mdr_load(mdr3),
    .pc_en(pce3), .rf_we_en(rfw3),
`ifdef MEM_ACCESS_SEQ_PERF_CNT_EN
    .cycle_cnt(cyc3), .instret_cnt(ins3),
`endif
    .halted(hlt3)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst1 = 1'b1; rd1 = 1'b0; wr1 = 1'b0; halt1 = 1'b0;
    pc1 = 32'h1000; da1 = 32'h0;
    rst3 = 1'b1; rd3 = 1'b0; wr3 = 1'b0; halt3 = 1'b0;
    pc3 = 32'h2000; da3 = 32'h0;
    tick();
    tick();
    chk("rst_mem_en", 32'(m1.mem_en), 32'd0);
    chk("rst_addr", m1.mem_addr, 32'h0);
    chk("rst_pc_en", 32'(pce1), 32'd0);
    chk("rst_halted", 32'(hlt1), 32'd0);

    // ADD: c0..c3
    rst1 = 1'b0;
    #1;
    chk("add_c0_en", 32'(m1.mem_en), 32'd1);
    chk("add_c0_addr", m1.mem_addr, 32'h1000);
    chk("add_c0_we", 32'(m1.mem_we), 32'd0);
`ifdef MEM_ACCESS_SEQ_PERF_CNT_EN
    chk("cyc_c0", cyc1, 32'd0);
`endif
    tick();
    chk("add_c1_ir", 32'(ir1), 32'd1);
    chk("add_c1_en", 32'(m1.mem_en), 32'd0);
    chk("add_c1_addr", m1.mem_addr, 32'h0);
    tick();
    chk("add_c2_pc_en", 32'(pce1), 32'd1);
    chk("add_c2_rf_we", 32'(rfw1), 32'd1);
    chk("add_c2_ir", 32'(ir1), 32'd0);
    pc1 = 32'h1004;
    tick();
    // load 0x100: c3..c9
    rd1 = 1'b1; da1 = 32'h100;
    #1;
    chk("ld_c3_en", 32'(m1.mem_en), 32'd1);
    chk("ld_c3_addr", m1.mem_addr, 32'h1004);
    chk("add_c3_pc_en", 32'(pce1), 32'd0);
`ifdef MEM_ACCESS_SEQ_PERF_CNT_EN
    chk("ins_after_add", ins1, 32'd1);
`endif
    tick();
    chk("ld_c4_ir", 32'(ir1), 32'd1);
    tick();
    chk("ld_c5_pc_en", 32'(pce1), 32'd0);
    chk("ld_c5_en", 32'(m1.mem_en), 32'd0);
    tick();
    chk("ld_c6_en", 32'(m1.mem_en), 32'd1);
    chk("ld_c6_addr", m1.mem_addr, 32'h100);
    chk("ld_c6_we", 32'(m1.mem_we), 32'd0);
    tick();
    chk("ld_c7_mdr", 32'(mdr1), 32'd1);
    chk("ld_c7_en", 32'(m1.mem_en), 32'd0);
    chk("ld_c7_pc_en", 32'(pce1), 32'd0);
    tick();
    chk("ld_c8_pc_en", 32'(pce1), 32'd1);
    chk("ld_c8_mdr", 32'(mdr1), 32'd0);
    pc1 = 32'h1008;
    tick();
    // store with read also high: c9..c14
    wr1 = 1'b1; da1 = 32'h200;
    #1;
    chk("st_c9_addr", m1.mem_addr, 32'h1008);
`ifdef MEM_ACCESS_SEQ_PERF_CNT_EN
    chk("ins_after_ld", ins1, 32'd2);
    chk("cyc_c9", cyc1, 32'd9);
`endif
    tick();
    tick();
    chk("st_c11_en", 32'(m1.mem_en), 32'd0);
    chk("st_c11_we", 32'(m1.mem_we), 32'd0);
    tick();
    chk("st_c12_we", 32'(m1.mem_we), 32'd1);
    chk("st_c12_addr", m1.mem_addr, 32'h200);
    tick();
    chk("st_c13_pc_en", 32'(pce1), 32'd1);
    chk("st_c13_mdr", 32'(mdr1), 32'd0);
    chk("st_c13_we", 32'(m1.mem_we), 32'd0);
    pc1 = 32'h100C;
    tick();
    // load then reset in DWAIT: c14..c18
    wr1 = 1'b0; rd1 = 1'b1; da1 = 32'h300;
    #1;
    chk("st_c14_en", 32'(m1.mem_en), 32'd1);
    tick();
    tick();
    tick();
    chk("ld2_c17_addr", m1.mem_addr, 32'h300);
    tick();
    chk("ld2_c18_mdr", 32'(mdr1), 32'd1);
    rst1 = 1'b1;
    tick();
    chk("rstdw_en", 32'(m1.mem_en), 32'd0);
    chk("rstdw_mdr", 32'(mdr1), 32'd0);
    chk("rstdw_pc_en", 32'(pce1), 32'd0);
    chk("rstdw_rf_we", 32'(rfw1), 32'd0);
    chk("rstdw_addr", m1.mem_addr, 32'h0);
    // halt with store pending
    rst1 = 1'b0; rd1 = 1'b0; wr1 = 1'b1;
    halt1 = 1'b1; da1 = 32'h400;
    #1;
    chk("rel_en", 32'(m1.mem_en), 32'd1);
    chk("rel_addr", m1.mem_addr, 32'h100C);
`ifdef MEM_ACCESS_SEQ_PERF_CNT_EN
    chk("rel_cyc", cyc1, 32'd0);
    chk("rel_ins", ins1, 32'd0);
`endif
    tick();
    tick();
    chk("hlt_ex_we", 32'(m1.mem_we), 32'd0);
    chk("hlt_ex_pc_en", 32'(pce1), 32'd0);
    chk("hlt_ex_en", 32'(m1.mem_en), 32'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hlt_halted", 32'(hlt1), 32'd1);
      chk("hlt_pc_en", 32'(pce1), 32'd0);
      chk("hlt_en", 32'(m1.mem_en), 32'd0);
      chk("hlt_we", 32'(m1.mem_we), 32'd0);
    end
`ifdef MEM_ACCESS_SEQ_PERF_CNT_EN
    chk("hlt_cyc", cyc1, 32'd3);
    chk("hlt_ins", ins1, 32'd0);
    // instret wrap via force
    rst1 = 1'b1; halt1 = 1'b0; wr1 = 1'b0;
    tick();
    chk("rst_halt_exit", 32'(hlt1), 32'd0);
    rst1 = 1'b0;
    force u1.instret_q = 32'hFFFF_FFFF;
    #1;
    release u1.instret_q;
    tick();
    tick();
    chk("wrap_c2_pc_en", 32'(pce1), 32'd1);
    tick();
    chk("wrap_ins", ins1, 32'd0);
`endif

    // MEM_LAT=3 store 0x40
    wr3 = 1'b1; da3 = 32'h40;
    rst3 = 1'b0;
    #1;
    chk("l3_c0_en", 32'(m3.mem_en), 32'd1);
    chk("l3_c0_addr", m3.mem_addr, 32'h2000);
    tick();
    chk("l3_c1_ir", 32'(ir3), 32'd0);
    tick();
    chk("l3_c2_ir", 32'(ir3), 32'd0);
    tick();
    chk("l3_c3_ir", 32'(ir3), 32'd1);
    tick();
    chk("l3_c4_en", 32'(m3.mem_en), 32'd0);
    chk("l3_c4_pc_en", 32'(pce3), 32'd0);
    tick();
    chk("l3_c5_we", 32'(m3.mem_we), 32'd1);
    chk("l3_c5_addr", m3.mem_addr, 32'h40);
    chk("l3_c5_en", 32'(m3.mem_en), 32'd1);
    tick();
    chk("l3_c6_pc_en", 32'(pce3), 32'd1);
    chk("l3_c6_mdr", 32'(mdr3), 32'd0);
    tick();
    chk("l3_c7_en", 32'(m3.mem_en), 32'd1);
    chk("l3_c7_addr", m3.mem_addr, 32'h2000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
